// File: rtl/mod_cnt_pkg.sv
// Shared definitions for the modulo counter controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding and default width/modulus constants.
package mod_cnt_pkg;

   localparam int CNT_WIDTH       = 4;
   localparam int CNT_DEFAULT_MOD = 9;

   // Encoding is visible on the state output, so the values are fixed.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/mod_cnt_ctrl_if.sv
// Control/status bundle between a host and the modulo counter controller.
// Latency: n/a (wires only).
// Backpressure: cfg_valid/cfg_ready handshake; start/stop/pause are plain requests.
// Ports: master drives cfg_*, start, stop, pause; slave drives cfg_ready, cnt,
//        wrap, done, busy, state, cfg_err.
interface mod_cnt_ctrl_if import mod_cnt_pkg::*; #(
   parameter int WIDTH = CNT_WIDTH
) ();

   logic             cfg_valid;
   logic             cfg_ready;
   logic [WIDTH-1:0] cfg_mod;
   logic [WIDTH-1:0] cfg_reps;
   logic             start;
   logic             stop;
   logic             pause;
   logic [WIDTH-1:0] cnt;
   logic             wrap;
   logic             done;
   logic             busy;
   logic [1:0]       state;
   logic             cfg_err;

   modport master (
      output cfg_valid, cfg_mod, cfg_reps, start, stop, pause,
      input  cfg_ready, cnt, wrap, done, busy, state, cfg_err
   );

   modport slave (
      input  cfg_valid, cfg_mod, cfg_reps, start, stop, pause,
      output cfg_ready, cnt, wrap, done, busy, state, cfg_err
   );

endinterface

// File: rtl/mod_cntr.sv
// Modulo-N counting datapath with a registered wrap pulse.
// Latency: cnt/wrap update on the edge where en or clr is sampled.
// Backpressure: none; en gates advance, clr has priority over en.
// Ports: clk, reset (async active-low), en, clr, mod in; cnt, wrap out.
module mod_cntr import mod_cnt_pkg::*; #(
   parameter int WIDTH = CNT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] mod,
   output logic [WIDTH-1:0] cnt,
   output logic             wrap
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt  <= '0;
         wrap <= 1'b0;
      end else if (clr) begin
         cnt  <= '0;
         wrap <= 1'b0;
      end else if (en) begin
         if (cnt == mod - WIDTH'(1)) begin
            cnt  <= '0;
            wrap <= 1'b1;
         end else begin
            cnt  <= cnt + WIDTH'(1);
            wrap <= 1'b0;
         end
      end else begin
         wrap <= 1'b0;
      end
   end

endmodule

// File: rtl/mod_cnt_ctrl.sv
// Modulo counter controller: configurable modulus and wrap count, run/pause/stop FSM.
// Latency: start sampled -> cnt=0 next edge, first increment one edge later.
// Backpressure: cfg_ready high only in IDLE; start/stop/pause outside their states are ignored.
// Ports: clk, reset (async active-low), bus (mod_cnt_ctrl_if.slave).
module mod_cnt_ctrl import mod_cnt_pkg::*; #(
   parameter int WIDTH       = CNT_WIDTH,
   parameter int DEFAULT_MOD = CNT_DEFAULT_MOD
) (
   input logic           clk,
   input logic           reset,
   mod_cnt_ctrl_if.slave bus
);

   state_t           state_r;
   logic [WIDTH-1:0] mod_r;
   logic [WIDTH-1:0] reps_r;
   logic [WIDTH-1:0] wrap_cnt_r;
   logic             done_r;
   logic             cfg_err_r;

   logic [WIDTH-1:0] cnt;
   logic             cntr_wrap;

   logic cfg_hs;
   logic start_go;
   logic stop_go;
   logic run_en;
   logic wrap_now;
   logic last_wrap;
   logic cntr_clr;

   assign cfg_hs   = bus.cfg_valid && (state_r == IDLE);
   // A same-cycle configuration handshake swallows start.
   assign start_go = bus.start && (state_r == IDLE) && !cfg_hs;
   assign stop_go  = bus.stop && ((state_r == RUN) || (state_r == PAUSE));
   // Stop and pause both freeze the count on the edge they are sampled.
   assign run_en   = (state_r == RUN) && !bus.pause && !bus.stop;
   assign wrap_now = run_en && (cnt == mod_r - WIDTH'(1));
   // The final wrap and DONE entry share one edge so done lines up with wrap.
   assign last_wrap = wrap_now && (reps_r != '0) && ((wrap_cnt_r + WIDTH'(1)) == reps_r);
   assign cntr_clr  = stop_go || start_go;

   mod_cntr #(.WIDTH(WIDTH)) u_cntr (
      .clk   (clk),
      .reset (reset),
      .en    (run_en),
      .clr   (cntr_clr),
      .mod   (mod_r),
      .cnt   (cnt),
      .wrap  (cntr_wrap)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= IDLE;
         mod_r      <= WIDTH'(DEFAULT_MOD);
         reps_r     <= '0;
         wrap_cnt_r <= '0;
         done_r     <= 1'b0;
         cfg_err_r  <= 1'b0;
      end else begin
         done_r    <= 1'b0;
         cfg_err_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (cfg_hs) begin
                  // An illegal modulus still completes the handshake, but is dropped.
                  if (bus.cfg_mod < WIDTH'(2)) begin
                     cfg_err_r <= 1'b1;
                  end else begin
                     mod_r  <= bus.cfg_mod;
                     reps_r <= bus.cfg_reps;
                  end
               end else if (start_go) begin
                  state_r    <= RUN;
                  wrap_cnt_r <= '0;
               end
            end
            RUN: begin
               if (bus.stop) begin
                  state_r <= IDLE;
               end else if (bus.pause) begin
                  state_r <= PAUSE;
               end else if (wrap_now) begin
                  // Saturate so continuous mode never aliases back to a small count.
                  if (wrap_cnt_r != '1) begin
                     wrap_cnt_r <= wrap_cnt_r + WIDTH'(1);
                  end
                  if (last_wrap) begin
                     state_r <= DONE;
                     done_r  <= 1'b1;
                  end
               end
            end
            PAUSE: begin
               if (bus.stop) begin
                  state_r <= IDLE;
               end else if (!bus.pause) begin
                  state_r <= RUN;
               end
            end
            DONE: begin
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.cfg_ready = (state_r == IDLE);
   assign bus.busy      = (state_r == RUN) || (state_r == PAUSE);
   assign bus.state     = state_r;
   assign bus.cnt       = cnt;
   assign bus.wrap      = cntr_wrap;
   assign bus.done      = done_r;
   assign bus.cfg_err   = cfg_err_r;

endmodule

// File: tb/tb_mod_cnt_ctrl.sv
// Bench for mod_cnt_ctrl: directed scenarios followed by random traffic.
// Latency: expectations are for the rising edge after each driven cycle.
// Backpressure: the driver pushes one expectation per cycle; the monitor pops and compares.
module tb_mod_cnt_ctrl;

   typedef struct packed {
      logic [1:0] state;
      logic [3:0] cnt;
      logic       wrap;
      logic       done;
      logic       busy;
      logic       rdy;
      logic       err;
   } exp_t;

   logic clk;
   logic reset;

   mod_cnt_ctrl_if #(.WIDTH(4)) bus ();

   mod_cnt_ctrl #(.WIDTH(4), .DEFAULT_MOD(9)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errs   = 0;
   exp_t exp_q[$];

   // Reference model: 0 idle, 1 run, 2 pause, 3 done.
   int m_state, m_cnt, m_mod, m_reps, m_wraps;
   int m_wrap, m_done, m_err;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void chk(string name, int act, int expv);
      n_checks++;
      if (act != expv) begin
         n_errs++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endfunction

   function automatic exp_t cur_exp();
      exp_t e;
      e.state = m_state[1:0];
      e.cnt   = m_cnt[3:0];
      e.wrap  = (m_wrap != 0);
      e.done  = (m_done != 0);
      e.busy  = (m_state == 1) || (m_state == 2);
      e.rdy   = (m_state == 0);
      e.err   = (m_err != 0);
      return e;
   endfunction

   function automatic void model_reset();
      m_state = 0; m_cnt = 0; m_mod = 9; m_reps = 0; m_wraps = 0;
      m_wrap = 0; m_done = 0; m_err = 0;
   endfunction

   function automatic void model_step(int cv, int cm, int cr, int st, int sp, int pa);
      m_wrap = 0; m_done = 0; m_err = 0;
      case (m_state)
         0: begin
            if (cv != 0) begin
               if (cm < 2) m_err = 1;
               else begin m_mod = cm; m_reps = cr; end
            end else if (st != 0) begin
               m_state = 1; m_cnt = 0; m_wraps = 0;
            end
         end
         1: begin
            if (sp != 0) begin
               m_state = 0; m_cnt = 0;
            end else if (pa != 0) begin
               m_state = 2;
            end else begin
               m_cnt = (m_cnt + 1) % m_mod;
               if (m_cnt == 0) begin
                  m_wrap = 1;
                  m_wraps = (m_wraps < 15) ? m_wraps + 1 : 15;
                  if (m_reps != 0 && m_wraps == m_reps) begin
                     m_state = 3; m_done = 1;
                  end
               end
            end
         end
         2: begin
            if (sp != 0) begin
               m_state = 0; m_cnt = 0;
            end else if (pa == 0) begin
               m_state = 1;
            end
         end
         default: m_state = 0;
      endcase
   endfunction

   task automatic cycle(input logic cv, input logic [3:0] cm, input logic [3:0] cr,
                        input logic st, input logic sp, input logic pa);
      @(negedge clk);
      reset         = 1'b1;
      bus.cfg_valid = cv;
      bus.cfg_mod   = cm;
      bus.cfg_reps  = cr;
      bus.start     = st;
      bus.stop      = sp;
      bus.pause     = pa;
      model_step(int'(cv), int'(cm), int'(cr), int'(st), int'(sp), int'(pa));
      exp_q.push_back(cur_exp());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset         = 1'b0;
      bus.cfg_valid = 1'b0;
      bus.cfg_mod   = 4'd0;
      bus.cfg_reps  = 4'd0;
      bus.start     = 1'b0;
      bus.stop      = 1'b0;
      bus.pause     = 1'b0;
      #1;
      // Reset acts without waiting for a clock edge.
      chk("async_state", int'(bus.state), 0);
      chk("async_cnt", int'(bus.cnt), 0);
      chk("async_wrap", int'(bus.wrap), 0);
      chk("async_done", int'(bus.done), 0);
      chk("async_busy", int'(bus.busy), 0);
      chk("async_rdy", int'(bus.cfg_ready), 1);
      model_reset();
      exp_q.push_back(cur_exp());
   endtask

   // Monitor: compares every output against the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("state", int'(bus.state), int'(e.state));
            chk("cnt", int'(bus.cnt), int'(e.cnt));
            chk("wrap", int'(bus.wrap), int'(e.wrap));
            chk("done", int'(bus.done), int'(e.done));
            chk("busy", int'(bus.busy), int'(e.busy));
            chk("cfg_ready", int'(bus.cfg_ready), int'(e.rdy));
            chk("cfg_err", int'(bus.cfg_err), int'(e.err));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset         = 1'b0;
      bus.cfg_valid = 1'b0;
      bus.cfg_mod   = 4'd0;
      bus.cfg_reps  = 4'd0;
      bus.start     = 1'b0;
      bus.stop      = 1'b0;
      bus.pause     = 1'b0;
      model_reset();

      do_reset();
      // Default modulus, continuous; start on the first edge after reset release.
      cycle(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      idle(30);
      cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
      // mod 5, three wraps, then DONE and back to IDLE.
      cycle(1'b1, 4'd5, 4'd3, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      idle(20);
      // Illegal modulus after reset leaves the default in place.
      do_reset();
      cycle(1'b1, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      idle(12);
      // Pause at cnt=4 for three cycles.
      cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      idle(4);
      for (int i = 0; i < 3; i++) cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
      idle(8);
      // Stop at cnt=8, the cycle a wrap would be due.
      cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      idle(8);
      cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1);
      idle(2);
      // Reset mid-run at cnt=6, then restart.
      cycle(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      idle(6);
      do_reset();
      cycle(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      idle(5);
      cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
      // Start with a same-cycle config is ignored; start in RUN is ignored.
      cycle(1'b1, 4'd6, 4'd2, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      idle(3);
      cycle(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      idle(12);

      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            cycle($urandom_range(0, 9) == 0,
                  4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 4)),
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 39) == 0,
                  $urandom_range(0, 7) == 0);
         end
      end

      idle(1);
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
